sseg_decoder: RTL and testbench

Readback monitor for the multiplexed 7-segment display bus: samples the active-low anode enables and active-low segment lines, waits for each pattern to settle, and decodes it back into the 3-bit point code per digit. It sits beside the display driver, on the same `an`/`sseg` nets feeding the board pins. It gives the score logic and the testbench a registered, checked copy of what is actually being shown. It also flags any pattern outside the display alphabet.

---
 rtl/sseg_decoder.sv | 179 +++++++++++++++++
 tb/tb_sseg_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : sseg_decoder
// Purpose  : Readback monitor for a multiplexed 7-segment display bus.
//            Samples the active-low anode enables and segment lines, waits
//            for each {anode, segment} pattern to stay stable for
//            STABLE_CYCLES consecutive samples, then decodes the segment
//            pattern into a 3-bit point code and stores it for the selected
//            digit. Patterns outside the display alphabet, and bus
//            contention (more than one anode active), raise an error pulse.
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            i_an     - [3:0] anode enables, active low, bit i = digit i
//            i_sseg   - [6:0] segment lines gfedcba, active low
//            o_point  - [11:0] decoded codes, digit i in [3i+2:3i]
//            o_valid  - [3:0] digit i captured at least once
//            o_upd    - pulse when a digit gets a new value / first valid
//            o_err    - pulse on an illegal capture
// Config   : SSEG_DECODER_SYNC_EN - when defined, a two-flop synchronizer
//            sits in front of the sample register (adds 2 cycles latency).
// Revision : 1.0 - initial release
// ============================================================================
module sseg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  i_an,
    input  logic [6:0]  i_sseg,
    output logic [11:0] o_point,
    output logic [3:0]  o_valid,
    output logic        o_upd,
    output logic        o_err
);

    // Idle bus: all anodes off, all segments off.
    localparam logic [10:0] c_IDLE   = {4'hF, 7'h7F};
    localparam logic [7:0]  c_STABLE = 8'(STABLE_CYCLES);

    localparam logic [0:0]  c_SETTLE = 1'b0;
    localparam logic [0:0]  c_HOLD   = 1'b1;

    localparam logic [2:0]  c_CODE_UNKNOWN = 3'b110;

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic [10:0] w_in;

`ifdef SSEG_DECODER_SYNC_EN
    logic [10:0] r_sync1;
    logic [10:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= c_IDLE;
            r_sync2 <= c_IDLE;
        end else begin
            r_sync1 <= {i_an, i_sseg};
            r_sync2 <= r_sync1;
        end
    end

    assign w_in = r_sync2;
`else
    assign w_in = {i_an, i_sseg};
`endif

    // ------------------------------------------------------------------
    // Sample register, stability counter and settle/hold FSM
    // ------------------------------------------------------------------
    logic [10:0] r_smp;
    logic [7:0]  r_cnt;
    logic [0:0]  r_state;

    logic        w_same;
    logic        w_capture;

    assign w_same = (w_in == r_smp);

    // Capture fires on the edge where the counter would reach the threshold.
    // A change arriving on that same edge clears w_same and wins.
    assign w_capture = w_same && (r_state == c_SETTLE) &&
                       (r_cnt == (c_STABLE - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp   <= c_IDLE;
            r_cnt   <= 8'd0;
            r_state <= c_SETTLE;
        end else begin
            r_smp <= w_in;
            if (!w_same) begin
                r_cnt   <= 8'd0;
                r_state <= c_SETTLE;
            end else begin
                if (r_cnt != c_STABLE) begin
                    r_cnt <= r_cnt + 8'd1;
                end
                if (w_capture) begin
                    r_state <= c_HOLD;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode of the held sample
    // ------------------------------------------------------------------
    function automatic logic [2:0] f_decode(input logic [6:0] seg);
        logic [2:0] code;
        case (seg)
            7'b1000000: code = 3'b000;
            7'b1111001: code = 3'b001;
            7'b0100100: code = 3'b010;
            7'b0110000: code = 3'b011;
            7'b0001100: code = 3'b100;  // P
            7'b0111111: code = 3'b101;  // minus
            7'b0110110: code = 3'b111;  // blank / X
            default:    code = c_CODE_UNKNOWN;
        endcase
        return code;
    endfunction

    logic [2:0]  w_code;
    logic        w_unknown;
    logic [3:0]  w_an_low;
    logic        w_multi;
    logic        w_one;
    logic        w_wr;
    logic        w_changed;

    logic [11:0] r_point;
    logic [3:0]  r_valid;
    logic        r_upd;
    logic        r_err;

    assign w_code    = f_decode(r_smp[6:0]);
    assign w_unknown = (w_code == c_CODE_UNKNOWN);
    assign w_an_low  = ~r_smp[10:7];
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign w_multi   = ((w_an_low & (w_an_low - 4'd1)) != 4'd0);
    assign w_one     = (w_an_low != 4'd0) && !w_multi;
    assign w_wr      = w_capture && w_one;

    always_comb begin
        w_changed = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w_an_low[i] && ((r_point[3*i +: 3] != w_code) || !r_valid[i])) begin
                w_changed = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_point <= 12'h000;
            r_valid <= 4'h0;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_wr && w_an_low[i]) begin
                    r_point[3*i +: 3] <= w_code;
                    r_valid[i]        <= 1'b1;
                end
            end
            r_upd <= w_wr && w_changed;
            r_err <= w_capture && ((w_one && w_unknown) || w_multi);
        end
    end

    assign o_point = r_point;
    assign o_valid = r_valid;
    assign o_upd   = r_upd;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sseg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_decoder
// Purpose  : Self-checking bench for sseg_decoder. A behavioural model based
//            on run lengths of identical samples predicts the outputs every
//            cycle; directed scenarios pin the model with literal values,
//            then randomized bus traffic (with occasional async resets)
//            exercises the rest.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_decoder;

    localparam int S = 4;
    localparam logic [10:0] c_IDLE = {4'hF, 7'h7F};

    localparam logic [6:0] c_PAT [7] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                         7'b0110000, 7'b0001100, 7'b0111111,
                                         7'b0110110};
    localparam logic [2:0] c_COD [7] = '{3'b000, 3'b001, 3'b010, 3'b011,
                                         3'b100, 3'b101, 3'b111};

    logic        clk;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [11:0] point;
    logic [3:0]  valid;
    logic        upd;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_upd  = 0;
    int cnt_err  = 0;
    int cnt_both = 0;

    sseg_decoder #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_an    (an),
        .i_sseg  (sseg),
        .o_point (point),
        .o_valid (valid),
        .o_upd   (upd),
        .o_err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: count how many consecutive edges saw the same
    // pattern (the reset value counts as one). The pattern is captured on
    // the edge where that run first reaches S+1.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [10:0] prev;
        logic [10:0] s1;
        logic [10:0] s2;
        logic [8:0]  run;
        logic [11:0] point;
        logic [3:0]  valid;
        logic        upd;
        logic        err;
    } mstate_t;

    mstate_t m;

    function automatic logic [2:0] m_decode(input logic [6:0] s);
        for (int k = 0; k < 7; k++) begin
            if (c_PAT[k] == s) return c_COD[k];
        end
        return 3'b110;
    endfunction

    function automatic mstate_t m_reset();
        mstate_t r;
        r.prev  = c_IDLE;
        r.s1    = c_IDLE;
        r.s2    = c_IDLE;
        r.run   = 9'd1;
        r.point = 12'h000;
        r.valid = 4'h0;
        r.upd   = 1'b0;
        r.err   = 1'b0;
        return r;
    endfunction

    function automatic mstate_t m_step(input mstate_t cur, input logic [10:0] pin);
        mstate_t     n;
        logic [10:0] smp;
        logic [3:0]  lows;
        logic [2:0]  code;
        int          idx;
        n = cur;
`ifdef SSEG_DECODER_SYNC_EN
        smp  = cur.s2;
        n.s2 = cur.s1;
        n.s1 = pin;
`else
        smp = pin;
`endif
        n.upd  = 1'b0;
        n.err  = 1'b0;
        n.prev = smp;
        if (smp != cur.prev)            n.run = 9'd1;
        else if (cur.run < 9'(S + 1))   n.run = cur.run + 9'd1;
        if (n.run == 9'(S + 1) && cur.run != 9'(S + 1)) begin
            lows = ~smp[10:7];
            code = m_decode(smp[6:0]);
            if ($countones(lows) == 1) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (lows[k]) idx = k;
                if (cur.point[3*idx +: 3] != code || !cur.valid[idx]) n.upd = 1'b1;
                n.point[3*idx +: 3] = code;
                n.valid[idx]        = 1'b1;
                if (code == 3'b110) n.err = 1'b1;
            end else if ($countones(lows) >= 2) begin
                n.err = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= m_step(m, {an, sseg});
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus pulse counters used by
    // the directed scenarios.
    always @(negedge clk) begin
        chk("model_point", 32'(point), 32'(m.point));
        chk("model_valid", 32'(valid), 32'(m.valid));
        chk("model_upd",   32'(upd),   32'(m.upd));
        chk("model_err",   32'(err),   32'(m.err));
        if (upd === 1'b1) cnt_upd++;
        if (err === 1'b1) cnt_err++;
        if (upd === 1'b1 && err === 1'b1) cnt_both++;
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an   = a;
        sseg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        cnt_upd  = 0;
        cnt_err  = 0;
        cnt_both = 0;
    endtask

    // Assert reset part-way through a cycle, check outputs clear at once.
    task automatic async_reset(input bit check_now);
        #3 rst_n = 1'b0;
        #1;
        if (check_now) begin
            chk("async_rst_point", 32'(point), 32'h0);
            chk("async_rst_valid", 32'(valid), 32'h0);
            chk("async_rst_upd",   32'(upd),   32'h0);
            chk("async_rst_err",   32'(err),   32'h0);
        end
        an   = 4'hF;
        sseg = 7'h7F;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [11:0] saved_point;
    logic [3:0]  saved_valid;

    initial begin
        rst_n = 1'b0;
        an    = 4'hF;
        sseg  = 7'h7F;
        repeat (3) @(negedge clk);
        chk("reset_point", 32'(point), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_upd",   32'(upd),   32'h0);
        chk("reset_err",   32'(err),   32'h0);
        rst_n = 1'b1;
        hold(4'hF, 7'h7F, 6);

        // Single digit, with exact capture latency.
        clr_counts();
        hold(4'b1110, 7'b0100100, S);
        chk("t1_not_yet_valid", 32'(valid), 32'h0);
        hold(4'b1110, 7'b0100100, 1);
        chk("t1_valid_on_time", 32'(valid), 32'h1);
        hold(4'b1110, 7'b0100100, 5);
        chk("t1_point", 32'(point[2:0]), 32'h2);
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_upd_cnt", 32'(cnt_upd), 32'd1);
        chk("t1_err_cnt", 32'(cnt_err), 32'd0);

        // Scan all four digits.
        clr_counts();
        hold(4'b1110, 7'b1000000, 8); hold(4'hF, 7'h7F, 2);
        hold(4'b1101, 7'b1111001, 8); hold(4'hF, 7'h7F, 2);
        hold(4'b1011, 7'b0001100, 8); hold(4'hF, 7'h7F, 2);
        hold(4'b0111, 7'b0111111, 8); hold(4'hF, 7'h7F, 2);
        chk("t2_point", 32'(point), 32'(12'b101_100_001_000));
        chk("t2_valid", 32'(valid), 32'hF);
        chk("t2_upd_cnt", 32'(cnt_upd), 32'd4);
        chk("t2_err_cnt", 32'(cnt_err), 32'd0);

        // Contention, then an unknown pattern landing in digit 0.
        saved_point = point;
        saved_valid = valid;
        clr_counts();
        hold(4'b1100, 7'b0100100, 8);
        chk("t4_contention_err", 32'(cnt_err), 32'd1);
        chk("t4_contention_upd", 32'(cnt_upd), 32'd0);
        chk("t4_point_kept", 32'(point), 32'(saved_point));
        chk("t4_valid_kept", 32'(valid), 32'(saved_valid));
        clr_counts();
        hold(4'b1110, 7'b1010101, 8);
        chk("t4_unknown_point", 32'(point[2:0]), 32'h6);
        chk("t4_unknown_both", 32'(cnt_both), 32'd1);
        chk("t4_unknown_err", 32'(cnt_err), 32'd1);

        // Same value re-captured after a blank gap.
        hold(4'hF, 7'h7F, 3);
        clr_counts();
        hold(4'b1011, 7'b0001100, 8);
        hold(4'hF, 7'h7F, 2);
        chk("t5_recapture_upd", 32'(cnt_upd), 32'd0);
        chk("t5_recapture_err", 32'(cnt_err), 32'd0);
        chk("t5_point", 32'(point[8:6]), 32'h4);

        // Reset in the middle of a settle window.
        hold(4'b0111, 7'b1111001, 2);
        async_reset(1'b1);
        hold(4'hF, 7'h7F, 6);

        // Glitch shorter than the settle window is rejected.
        clr_counts();
        hold(4'b1101, 7'b0110000, 3);
        hold(4'hF, 7'h7F, 7);
        chk("t3_glitch_valid", 32'(valid), 32'h0);
        chk("t3_glitch_point", 32'(point), 32'h0);
        chk("t3_glitch_upd", 32'(cnt_upd), 32'd0);

        // First capture after reset behaves like power-up.
        clr_counts();
        hold(4'b1110, 7'b0100100, 10);
        chk("t6_point", 32'(point), 32'h002);
        chk("t6_valid", 32'(valid), 32'h1);
        chk("t6_upd_cnt", 32'(cnt_upd), 32'd1);

        // Randomized bus traffic.
        for (int seg = 0; seg < 400; seg++) begin
            logic [3:0] a;
            logic [6:0] s;
            int         sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: a = 4'b1110;
                1: a = 4'b1101;
                2: a = 4'b1011;
                3: a = 4'b0111;
                4: a = 4'b1111;
                default: a = 4'($urandom);
            endcase
            sel = int'($urandom_range(0, 7));
            if (sel < 7) s = c_PAT[sel];
            else         s = 7'($urandom);
            hold(a, s, int'($urandom_range(1, 2 * S)));
            if ($urandom_range(0, 59) == 0) async_reset(1'b0);
        end
        hold(4'hF, 7'h7F, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
